// File: rtl/mod_147_14_multi.sv
// Multi-channel link monitor: per-channel DOWN/PENDING/UP/HOLD state machine with
// stabilise and hold timers, a saturating link-fail counter, and all/any-up summary flags.
module mod_147_14_multi #(
  parameter int NUM_CH        = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int HOLD_CYCLES   = 3,
  parameter int TIMER_W       = 16,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    pma_reset,
  input  logic [NUM_CH-1:0]       link_control,
  input  logic [NUM_CH-1:0]       pcs_status,
  input  logic [NUM_CH-1:0]       loc_rcv_status,
  input  logic                    fail_count_clr,
  output logic [2*NUM_CH-1:0]     mod_147_14_state,
  output logic [NUM_CH-1:0]       link_status,
  output logic [NUM_CH*CNT_W-1:0] link_fail_count,
  output logic                    all_link_ok,
  output logic                    any_link_ok
);

  typedef enum logic [1:0] {
    LINK_DOWN    = 2'b00,
    LINK_PENDING = 2'b01,
    LINK_UP      = 2'b10,
    LINK_HOLD    = 2'b11
  } state_e;

  // Terminal timer values; a zero cycle count bypasses the timed state entirely.
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'((STABLE_CYCLES > 0) ? STABLE_CYCLES - 1 : 0);
  localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};

  state_e               state_q  [NUM_CH];
  state_e               state_d  [NUM_CH];
  logic [TIMER_W-1:0]   timer_q  [NUM_CH];
  logic [TIMER_W-1:0]   timer_d  [NUM_CH];
  logic [CNT_W-1:0]     cnt_q    [NUM_CH];
  logic [CNT_W-1:0]     cnt_d    [NUM_CH];
  logic [NUM_CH-1:0]    status_q;
  logic [NUM_CH-1:0]    status_d;
  logic [NUM_CH-1:0]    good_s;

  assign good_s = ~pcs_status & loc_rcv_status;

  always_comb begin
    status_d = {NUM_CH{1'b1}};
    for (int i = 0; i < NUM_CH; i++) begin
      logic fail_ev;
      fail_ev    = 1'b0;
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      if (link_control[i]) begin
        state_d[i] = LINK_DOWN;
        timer_d[i] = '0;
      end else begin
        case (state_q[i])
          LINK_DOWN: begin
            if (good_s[i]) begin
              state_d[i] = (STABLE_CYCLES == 0) ? LINK_UP : LINK_PENDING;
              timer_d[i] = '0;
            end else begin
              state_d[i] = LINK_DOWN;
            end
          end
          LINK_PENDING: begin
            if (!good_s[i]) begin
              state_d[i] = LINK_DOWN;
              timer_d[i] = '0;
            end else if (timer_q[i] == STABLE_LAST) begin
              state_d[i] = LINK_UP;
              timer_d[i] = '0;
            end else begin
              timer_d[i] = timer_q[i] + TIMER_W'(1);
            end
          end
          LINK_UP: begin
            if (!good_s[i]) begin
              timer_d[i] = '0;
              if (HOLD_CYCLES == 0) begin
                state_d[i] = LINK_DOWN;
                fail_ev    = 1'b1;
              end else begin
                state_d[i] = LINK_HOLD;
              end
            end else begin
              state_d[i] = LINK_UP;
            end
          end
          LINK_HOLD: begin
            if (good_s[i]) begin
              state_d[i] = LINK_UP;
              timer_d[i] = '0;
            end else if (timer_q[i] == HOLD_LAST) begin
              state_d[i] = LINK_DOWN;
              timer_d[i] = '0;
              fail_ev    = 1'b1;
            end else begin
              timer_d[i] = timer_q[i] + TIMER_W'(1);
            end
          end
          default: begin
            state_d[i] = LINK_DOWN;
            timer_d[i] = '0;
          end
        endcase
      end

      status_d[i] = ((state_d[i] == LINK_UP) || (state_d[i] == LINK_HOLD)) ? 1'b0 : 1'b1;

      // A clear coinciding with a failure leaves 1 so that failure is still recorded.
      if (fail_count_clr) begin
        cnt_d[i] = fail_ev ? CNT_W'(1) : '0;
      end else if (fail_ev && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge pma_reset) begin
    if (pma_reset) begin
      status_q <= {NUM_CH{1'b1}};
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= LINK_DOWN;
        timer_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      status_q <= status_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign mod_147_14_state[2*g+1:2*g]        = state_q[g];
    assign link_fail_count[CNT_W*(g+1)-1:CNT_W*g] = cnt_q[g];
  end

  assign link_status = status_q;
  assign all_link_ok = ~|status_q;
  assign any_link_ok = ~&status_q;

endmodule

// File: tb/tb_mod_147_14_multi.sv
// Randomised bench: a run-length reference model (consecutive good/bad sample counts)
// predicts state, status, counters and aggregates for a default DUT and a 1-channel
// CNT_W=2 instance with zero stabilise/hold times.
module tb_mod_147_14_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ctl, pcs, rcv;
  logic        clr;

  logic [7:0]  st_m;
  logic [3:0]  ls_m;
  logic [31:0] cnt_m;
  logic        all_m, any_m;
  logic [1:0]  st_s;
  logic [0:0]  ls_s;
  logic [1:0]  cnt_s;
  logic        all_s, any_s;

  mod_147_14_multi dut (
    .clk(clk), .pma_reset(rst), .link_control(ctl[3:0]), .pcs_status(pcs[3:0]),
    .loc_rcv_status(rcv[3:0]), .fail_count_clr(clr), .mod_147_14_state(st_m),
    .link_status(ls_m), .link_fail_count(cnt_m), .all_link_ok(all_m), .any_link_ok(any_m)
  );

  mod_147_14_multi #(.NUM_CH(1), .STABLE_CYCLES(0), .HOLD_CYCLES(0), .TIMER_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .pma_reset(rst), .link_control(ctl[4:4]), .pcs_status(pcs[4:4]),
    .loc_rcv_status(rcv[4:4]), .fail_count_clr(clr), .mod_147_14_state(st_s),
    .link_status(ls_s), .link_fail_count(cnt_s), .all_link_ok(all_s), .any_link_ok(any_s)
  );

  always #5 clk = ~clk;

  // Reference model: channel is up after STABLE+1 consecutive good samples, down after HOLD+1 bad.
  int stab [5] = '{8, 8, 8, 8, 0};
  int hold [5] = '{3, 3, 3, 3, 0};
  int cmax [5] = '{255, 255, 255, 255, 3};
  int up [5], grun [5], brun [5], cnt [5];
  int run_left [5];
  bit cur_good [5];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s ch%0d @%0t: got %0d, expected %0d", tag, ch, $time, obs, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 5; c++) begin
      up[c] = 0; grun[c] = 0; brun[c] = 0; cnt[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < 5; c++) begin
      bit good, ev;
      good = !pcs[c] && rcv[c];
      ev   = 1'b0;
      if (ctl[c]) begin
        up[c] = 0; grun[c] = 0; brun[c] = 0;
      end else if (up[c] == 0) begin
        grun[c] = good ? grun[c] + 1 : 0;
        if (grun[c] >= stab[c] + 1) begin up[c] = 1; brun[c] = 0; end
      end else begin
        brun[c] = good ? 0 : brun[c] + 1;
        if (brun[c] >= hold[c] + 1) begin up[c] = 0; grun[c] = 0; ev = 1'b1; end
      end
      if (clr) cnt[c] = ev ? 1 : 0;
      else if (ev && cnt[c] < cmax[c]) cnt[c] = cnt[c] + 1;
    end
  endtask

  function automatic int exp_state(input int c);
    if (up[c] == 0) return (grun[c] == 0) ? 0 : 1;
    else return (brun[c] == 0) ? 2 : 3;
  endfunction

  task automatic compare_all();
    int n_up;
    n_up = 0;
    for (int c = 0; c < 4; c++) begin
      check_val("state", c, 32'(st_m[2*c +: 2]), 32'(exp_state(c)));
      check_val("link_status", c, 32'(ls_m[c]), 32'(up[c] ? 0 : 1));
      check_val("fail_count", c, 32'(cnt_m[8*c +: 8]), 32'(cnt[c]));
      n_up += up[c];
    end
    check_val("all_link_ok", 0, 32'(all_m), 32'(n_up == 4));
    check_val("any_link_ok", 0, 32'(any_m), 32'(n_up > 0));
    check_val("sat_state", 4, 32'(st_s), 32'(exp_state(4)));
    check_val("sat_link_status", 4, 32'(ls_s), 32'(up[4] ? 0 : 1));
    check_val("sat_fail_count", 4, 32'(cnt_s), 32'(cnt[4]));
    check_val("sat_all_link_ok", 4, 32'(all_s), 32'(up[4]));
    check_val("sat_any_link_ok", 4, 32'(any_s), 32'(up[4]));
  endtask

  task automatic drive_random(input int clr_pct);
    for (int c = 0; c < 5; c++) begin
      if (run_left[c] == 0) begin
        cur_good[c] = !cur_good[c];
        run_left[c] = $urandom_range(1, 14);
      end
      run_left[c]--;
      if (cur_good[c]) begin
        pcs[c] = 1'b0; rcv[c] = 1'b1;
      end else begin
        case ($urandom_range(0, 2))
          0: begin pcs[c] = 1'b1; rcv[c] = 1'b1; end
          1: begin pcs[c] = 1'b0; rcv[c] = 1'b0; end
          default: begin pcs[c] = 1'b1; rcv[c] = 1'b0; end
        endcase
      end
      ctl[c] = ($urandom_range(0, 99) == 0);
    end
    clr = ($urandom_range(0, 99) < clr_pct);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge occurs.
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    #1 compare_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ctl = '0; pcs = '1; rcv = '0; clr = 1'b0;
    for (int c = 0; c < 5; c++) begin run_left[c] = 0; cur_good[c] = 1'b0; end
    model_reset();
    #1 compare_all();
    @(posedge clk);
    #1 compare_all();
    rst = 1'b0;

    // Held good after reset: channels rise after exactly STABLE+1 edges.
    pcs = '0; rcv = '1;
    for (int k = 0; k < 12; k++) step();

    for (int k = 0; k < 1500; k++) begin
      drive_random(0);
      step();
      if (k == 700) mid_reset();
    end
    for (int k = 0; k < 1500; k++) begin
      drive_random(8);
      step();
      if (k == 900) mid_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
